// File: rtl/melody_pkg.sv
// Shared types, codes and the pitch-to-period helper for the melody sequencer.
package melody_pkg;

  typedef enum logic [2:0] {StIdle, StWait, StDecode, StPlay, StGap, StDone} state_e;

  localparam logic [7:0]  REST_CODE = 8'h00;
  localparam logic [7:0]  END_CODE  = 8'hFF;
  localparam int unsigned NUM_PITCH = 36;

  // Equal temperament around A4 = 440 Hz (code 0x0A); elaboration-time only.
  function automatic logic [19:0] pitch_period(input int unsigned code, input int unsigned clk_hz);
    return 20'($rtoi(real'(clk_hz) / (880.0 * (2.0 ** ((real'(code) - 10.0) / 12.0)))) - 1);
  endfunction

endpackage

// File: rtl/melody_sequencer_if.sv
// Control, note-ROM and generator-drive signals of the melody sequencer.
interface melody_sequencer_if #(
  parameter int unsigned ADDR_W = 8
);
  logic              start;
  logic              stop;
  logic              loop_en;
  logic [ADDR_W-1:0] rom_addr;
  logic [15:0]       rom_data;
  logic              pwm_en;
  logic [19:0]       pwm_param;
  logic              busy;
  logic              done;

  modport master (
    output start, stop, loop_en, rom_data,
    input  rom_addr, pwm_en, pwm_param, busy, done
  );

  modport slave (
    input  start, stop, loop_en, rom_data,
    output rom_addr, pwm_en, pwm_param, busy, done
  );
endinterface

// File: rtl/pitch_lut.sv
// Combinational pitch code to half-period count; rests and out-of-range codes give 0.
module pitch_lut
  import melody_pkg::*;
#(
  parameter int unsigned CLK_HZ = 50_000_000
) (
  input  logic [7:0]  i_code,
  output logic [19:0] o_param,
  output logic        o_tone
);

  logic [19:0] w_table [64];

  for (genvar g = 0; g < 64; g++) begin : g_tab
    localparam logic [19:0] P = ((g >= 1) && (g <= NUM_PITCH)) ? pitch_period(g, CLK_HZ) : 20'd0;
    assign w_table[g] = P;
  end

  always_comb begin
    o_tone  = (i_code != REST_CODE) && (i_code <= 8'(NUM_PITCH));
    o_param = o_tone ? w_table[i_code[5:0]] : 20'd0;
  end

endmodule

// File: rtl/melody_sequencer.sv
// Melody sequencer: walks a synchronous note ROM and times notes, gaps and rests
// to drive the enable/period inputs of a buzzer square-wave generator.
module melody_sequencer
  import melody_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 50_000_000,
  parameter int unsigned BEAT_TICKS = 3_125_000,
  parameter int unsigned GAP_TICKS  = 500_000,
  parameter int unsigned ADDR_W     = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  melody_sequencer_if.slave bus
);

  state_e            r_state, w_state_d;
  logic [31:0]       r_cnt, w_cnt_d;
  logic [ADDR_W-1:0] r_addr, w_addr_d;
  logic [19:0]       r_param, w_param_d;
  logic              r_pwm_en, w_pwm_en_d;
  logic              r_wrap, w_wrap_d;

  logic [7:0]  w_pitch;
  logic [7:0]  w_dur;
  logic [19:0] w_lut_param;
  logic        w_is_tone;
  logic        w_end;
  logic        w_cnt_last;
  logic [31:0] w_note_ticks;

  assign w_pitch      = bus.rom_data[15:8];
  assign w_dur        = (bus.rom_data[7:0] == 8'd0) ? 8'd1 : bus.rom_data[7:0];
  // Leaving the last address acts like an end marker instead of wrapping.
  assign w_end        = r_wrap || (w_pitch == END_CODE);
  assign w_cnt_last   = (r_cnt == 32'd1);
  assign w_note_ticks = 32'(w_dur) * 32'(BEAT_TICKS) - 32'(GAP_TICKS);

  pitch_lut #(
    .CLK_HZ(CLK_HZ)
  ) u_pitch_lut (
    .i_code (w_pitch),
    .o_param(w_lut_param),
    .o_tone (w_is_tone)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= StIdle;
      r_cnt    <= '0;
      r_addr   <= '0;
      r_param  <= '0;
      r_pwm_en <= 1'b0;
      r_wrap   <= 1'b0;
    end else begin
      r_state  <= w_state_d;
      r_cnt    <= w_cnt_d;
      r_addr   <= w_addr_d;
      r_param  <= w_param_d;
      r_pwm_en <= w_pwm_en_d;
      r_wrap   <= w_wrap_d;
    end
  end

  always_comb begin : next_state
    w_state_d = r_state;
    if (bus.stop) begin
      w_state_d = StIdle;
    end else begin
      unique case (r_state)
        StIdle:   if (bus.start) w_state_d = StWait;
        StWait:   w_state_d = StDecode;
        StDecode: begin
          if (w_end) w_state_d = bus.loop_en ? StWait : StDone;
          else       w_state_d = StPlay;
        end
        StPlay:   if (w_cnt_last) w_state_d = StGap;
        StGap:    if (w_cnt_last) w_state_d = StDecode;
        StDone:   w_state_d = StIdle;
        default:  w_state_d = StIdle;
      endcase
    end
  end

  always_comb begin : datapath
    w_cnt_d    = r_cnt;
    w_addr_d   = r_addr;
    w_param_d  = r_param;
    w_pwm_en_d = r_pwm_en;
    w_wrap_d   = r_wrap;
    unique case (r_state)
      StIdle: begin
        if (bus.start) begin
          w_addr_d = '0;
          w_wrap_d = 1'b0;
        end
      end
      StDecode: begin
        if (w_end) begin
          w_wrap_d = 1'b0;
          if (bus.loop_en) w_addr_d = '0;
        end else begin
          // Period only moves here, while the generator is disabled.
          if (w_is_tone) w_param_d = w_lut_param;
          w_pwm_en_d = w_is_tone;
          w_cnt_d    = w_note_ticks;
        end
      end
      StPlay: begin
        if (w_cnt_last) begin
          w_pwm_en_d = 1'b0;
          w_cnt_d    = 32'(GAP_TICKS);
          if (&r_addr) w_wrap_d = 1'b1;
          else         w_addr_d = r_addr + 1'b1;
        end else begin
          w_cnt_d = r_cnt - 32'd1;
        end
      end
      StGap:   w_cnt_d = r_cnt - 32'd1;
      default: ;
    endcase
    if (bus.stop) begin
      w_cnt_d    = '0;
      w_addr_d   = r_addr;
      w_param_d  = r_param;
      w_pwm_en_d = 1'b0;
      w_wrap_d   = 1'b0;
    end
  end

  always_comb begin : outputs
    bus.busy      = (r_state != StIdle) && (r_state != StDone);
    bus.done      = (r_state == StDone);
    bus.rom_addr  = r_addr;
    bus.pwm_en    = r_pwm_en;
    bus.pwm_param = r_param;
  end

endmodule

// File: tb/tb_melody_sequencer.sv
// Scoreboard bench: a note-level model predicts tone/done events that a monitor checks.
module tb_melody_sequencer;

  localparam int BEAT = 8;
  localparam int GAP  = 2;

  typedef struct {
    bit is_done;
    int cyc;
    int len;
    int param;
  } ev_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   cyc = 0;
  int   g_t0 = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  logic [15:0] rom [16];
  ev_t  exp_q[$];

  melody_sequencer_if #(.ADDR_W(4)) bus ();

  melody_sequencer #(
    .CLK_HZ    (50_000_000),
    .BEAT_TICKS(BEAT),
    .GAP_TICKS (GAP),
    .ADDR_W    (4)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) bus.rom_data <= rom[bus.rom_addr];

  initial begin
    #600_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int ref_period(input int code);
    real f;
    f = 440.0 * (2.0 ** ((code - 10) / 12.0));
    return $rtoi(50_000_000.0 / (2.0 * f)) - 1;
  endfunction

  // Note-level prediction: each entry occupies dur*BEAT+1 cycles from its decode cycle.
  task automatic model(input int t0, input bit lp, input int tcut, output int tend);
    int d, a, s, len, du;
    logic [7:0] p;
    ev_t e;
    d = t0 + 2;
    a = 0;
    tend = tcut;
    while (d <= tcut) begin
      p = (a >= 16) ? 8'hFF : rom[a][15:8];
      if (p == 8'hFF) begin
        if (lp) begin
          a = 0;
          d += 2;
        end else begin
          if (d + 1 <= tcut) begin
            e.is_done = 1'b1; e.cyc = d + 1; e.len = 0; e.param = 0;
            exp_q.push_back(e);
          end
          tend = (d + 1 < tcut) ? d + 1 : tcut;
          return;
        end
      end else begin
        du = (rom[a][7:0] == 8'd0) ? 1 : int'(rom[a][7:0]);
        if (p >= 8'd1 && p <= 8'd36) begin
          s = d + 1;
          len = du * BEAT - GAP;
          if (s + len - 1 > tcut) len = tcut - s + 1;
          if (len > 0) begin
            e.is_done = 1'b0; e.cyc = s; e.len = len; e.param = ref_period(int'(p));
            exp_q.push_back(e);
          end
        end
        d += du * BEAT + 1;
        a++;
      end
    end
  endtask

  task automatic at_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Plays the current ROM; stop_off/sb_off are cycle offsets from the start pulse.
  task automatic run(input bit lp, input int stop_off, input int sb_off, input bit use_rst);
    int t0, tcut, tend;
    @(posedge clk); #1;
    t0 = cyc;
    g_t0 = t0;
    bus.loop_en = lp;
    bus.start = 1'b1;
    tcut = (stop_off > 0) ? t0 + stop_off : 32'h3fff_ffff;
    model(t0, lp, tcut, tend);
    if (sb_off >= tend - t0 - 1 || sb_off >= tcut - t0) sb_off = 0;
    @(posedge clk); #1;
    bus.start = 1'b0;
    while (cyc < tend + 3) begin
      bus.stop  = !use_rst && (cyc == tcut);
      bus.start = (sb_off > 0) && (cyc == t0 + sb_off);
      if (use_rst && cyc == tcut) begin
        #1 rst_n = 1'b0;
        #1;
        chk("async_rst_pwm_en", bus.pwm_en, 0);
        chk("async_rst_pwm_param", bus.pwm_param, 0);
        chk("async_rst_rom_addr", bus.rom_addr, 0);
        chk("async_rst_busy", bus.busy, 0);
        chk("async_rst_done", bus.done, 0);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
    end
    bus.stop  = 1'b0;
    bus.start = 1'b0;
    chk("queue_drained", exp_q.size(), 0);
    chk("busy_after_run", bus.busy, 0);
    exp_q.delete();
  endtask

  task automatic fill(input logic [15:0] w0, input logic [15:0] w1, input logic [15:0] w2);
    for (int i = 0; i < 16; i++) rom[i] = 16'hFF00;
    rom[0] = w0;
    rom[1] = w1;
    rom[2] = w2;
  endtask

  initial begin : monitor
    ev_t e;
    bit prev_en = 1'b0;
    bit moved = 1'b0;
    int rise_c = 0;
    int rise_p = 0;
    forever begin
      @(negedge clk);
      if (bus.pwm_en && !prev_en) begin
        rise_c = cyc;
        rise_p = int'(bus.pwm_param);
        moved  = 1'b0;
        chk("busy_during_tone", bus.busy, 1);
      end else if (bus.pwm_en && int'(bus.pwm_param) != rise_p) begin
        moved = 1'b1;
      end
      if (!bus.pwm_en && prev_en) begin
        if (exp_q.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL unexpected_tone: tone at cycle %0d, expected none", rise_c);
        end else begin
          e = exp_q.pop_front();
          chk("event_is_tone", e.is_done, 0);
          chk("tone_start_cycle", rise_c, e.cyc);
          chk("tone_length", cyc - rise_c, e.len);
          chk("tone_param", rise_p, e.param);
          chk("param_stable_in_tone", moved, 0);
        end
      end
      if (bus.done) begin
        chk("busy_low_on_done", bus.busy, 0);
        if (exp_q.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL unexpected_done: done at cycle %0d, expected none", cyc);
        end else begin
          e = exp_q.pop_front();
          chk("event_is_done", e.is_done, 1);
          chk("done_cycle", cyc, e.cyc);
        end
      end
      prev_en = bus.pwm_en;
    end
  end

  initial begin : stim
    bit lp;
    int so;
    bus.start = 1'b0;
    bus.stop = 1'b0;
    bus.loop_en = 1'b0;
    fill(16'hFF00, 16'hFF00, 16'hFF00);
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_rom_addr", bus.rom_addr, 0);
    chk("reset_pwm_en", bus.pwm_en, 0);
    chk("reset_pwm_param", bus.pwm_param, 0);
    chk("reset_busy", bus.busy, 0);
    chk("reset_done", bus.done, 0);
    rst_n = 1'b1;

    // Rest first: generator stays off and the period stays at its reset value.
    fill(16'h0001, 16'h0101, 16'hFF00);
    fork
      run(1'b0, -1, 0, 1'b0);
      begin
        @(posedge clk); #2;
        at_cyc(g_t0 + 6);
        chk("rest_pwm_en_low", bus.pwm_en, 0);
        chk("rest_param_held", bus.pwm_param, 0);
        chk("busy_while_rest", bus.busy, 1);
      end
    join

    fill(16'h0A02, 16'hFF00, 16'hFF00);
    run(1'b0, -1, 0, 1'b0);

    fill(16'h0101, 16'hFF00, 16'hFF00);
    fork
      run(1'b1, 31, 0, 1'b0);
      begin
        @(posedge clk); #2;
        at_cyc(g_t0 + 11);
        chk("loop_addr_at_marker", bus.rom_addr, 1);
        at_cyc(g_t0 + 12);
        chk("loop_addr_rewound", bus.rom_addr, 0);
        chk("loop_busy_held", bus.busy, 1);
      end
    join

    // Stop in the second note's tone, then start+stop together, then a fresh start.
    fill(16'h0A02, 16'h0C02, 16'hFF00);
    fork
      run(1'b0, 24, 0, 1'b0);
      begin
        @(posedge clk); #2;
        at_cyc(g_t0 + 25);
        chk("stop_pwm_en", bus.pwm_en, 0);
        chk("stop_busy", bus.busy, 0);
        chk("stop_param_held", bus.pwm_param, ref_period(12));
        chk("stop_addr_held", bus.rom_addr, 1);
      end
    join
    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.stop = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.stop = 1'b0;
    chk("start_stop_same_cycle_busy", bus.busy, 0);
    chk("start_stop_same_cycle_addr", bus.rom_addr, 1);
    fork
      run(1'b0, -1, 0, 1'b0);
      begin
        @(posedge clk); #2;
        at_cyc(g_t0 + 1);
        chk("restart_addr_zero", bus.rom_addr, 0);
      end
    join

    // No end marker anywhere: leaving the last address finishes the tune.
    for (int i = 0; i < 16; i++) rom[i] = 16'h0C01;
    run(1'b0, -1, 0, 1'b0);

    // Start while busy, then reset during the first gap.
    fill(16'h0A02, 16'h0C01, 16'hFF00);
    run(1'b0, 17, 5, 1'b1);

    for (int r = 0; r < 25; r++) begin
      for (int i = 0; i < 16; i++) begin
        int k;
        logic [7:0] p;
        k = $urandom_range(0, 15);
        if (k == 0)      p = 8'h00;
        else if (k == 1) p = 8'($urandom_range(37, 254));
        else if (k == 2) p = 8'hFF;
        else             p = 8'($urandom_range(1, 36));
        rom[i] = {p, 8'($urandom_range(0, 3))};
      end
      lp = 1'($urandom_range(0, 1));
      so = (lp || ($urandom_range(0, 1) == 1)) ? int'($urandom_range(1, 250)) : -1;
      run(lp, so, int'($urandom_range(2, 40)), 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
